// File: rtl/boot_loader_ctl.sv
// boot_loader_ctl
// Boot-load sequencer for the RISC_PROCESSOR core. It holds the core in
// reset while a host streams N_WORDS 16-bit words into the single-port
// memory starting at START_ADR. It then releases the core and gives the
// memory port to it. A later start pulse re-enters load mode.
module boot_loader_ctl #(
  parameter int unsigned N_WORDS   = 256,
  parameter logic [15:0] START_ADR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_mw_en,
  output logic        cpu_reset,
  output logic [15:0] mem_adr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt
);

  // Index of the final word of a load. The WRITE state compares the
  // pre-increment count against it to decide whether the load is complete.
  localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);

  typedef enum logic [2:0] {
    HOLD,
    LOAD,
    WRITE,
    RELEASE,
    RUN
  } state_t;

  state_t      state;
  logic        ld_ready_q;
  logic        cpu_reset_q;
  logic        we_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] word_cnt_q;
  logic [15:0] adr_q;
  logic [15:0] data_q;

  // Sequencer FSM. All control outputs are registered and set on the
  // transition into the state that owns them. The loader address register
  // tracks START_ADR + word_cnt, so it wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      ld_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= 16'h0000;
      adr_q       <= START_ADR;
      data_q      <= 16'h0000;
    end else begin
      case (state)
        HOLD: begin
          if (start) begin
            state       <= LOAD;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            word_cnt_q  <= 16'h0000;
            adr_q       <= START_ADR;
          end
        end
        LOAD: begin
          if (ld_valid && ld_ready_q) begin
            state      <= WRITE;
            data_q     <= ld_data;
            ld_ready_q <= 1'b0;
            we_q       <= 1'b1;
          end
        end
        WRITE: begin
          we_q       <= 1'b0;
          word_cnt_q <= word_cnt_q + 16'd1;
          adr_q      <= adr_q + 16'd1;
          if (word_cnt_q == LAST_IDX) begin
            state <= RELEASE;
          end else begin
            state      <= LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        RELEASE: begin
          state       <= RUN;
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
        end
        RUN: begin
          if (start) begin
            state       <= LOAD;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            word_cnt_q  <= 16'h0000;
            adr_q       <= START_ADR;
          end
        end
        default: begin
          state       <= HOLD;
          ld_ready_q  <= 1'b0;
          cpu_reset_q <= 1'b1;
          we_q        <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // Memory port ownership: the core drives it combinationally in RUN, so a
  // core write in the cycle that start arrives still lands. Everywhere else
  // the loader registers own the port and core writes are dropped.
  assign mem_adr   = (state == RUN) ? cpu_adr   : adr_q;
  assign mem_din   = (state == RUN) ? cpu_dout  : data_q;
  assign mem_we    = (state == RUN) ? cpu_mw_en : we_q;

  assign ld_ready  = ld_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_boot_loader_ctl.sv
// tb_boot_loader_ctl
// Self-checking bench for boot_loader_ctl built with a small wrap-around
// configuration (4 words starting at 16'hFFFE). A directed vector table
// walks a full load, the run mux and a reload. A hand sequence covers an
// asynchronous reset in the middle of a write. Random traffic is then
// checked every cycle against a transaction-level model of the loader.
module tb_boot_loader_ctl;

  localparam int          N     = 4;
  localparam logic [15:0] START = 16'hFFFE;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic [15:0] cpu_adr;
  logic [15:0] cpu_dout;
  logic        cpu_mw_en;
  logic        cpu_reset;
  logic [15:0] mem_adr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  boot_loader_ctl #(
    .N_WORDS  (N),
    .START_ADR(START)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_adr  (cpu_adr),
    .cpu_dout (cpu_dout),
    .cpu_mw_en(cpu_mw_en),
    .cpu_reset(cpu_reset),
    .mem_adr  (mem_adr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .word_cnt (word_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: a load is active from start until the core is
  // released; words accepted vs. words written tells whether a write is
  // pending; after the last write there is one release cycle.
  bit          m_active;
  bit          m_run;
  int          m_acc;
  int          m_wr;
  logic [15:0] m_last;
  int          m_loads;

  task automatic model_clear();
    m_active = 1'b0;
    m_run    = 1'b0;
    m_acc    = 0;
    m_wr     = 0;
    m_last   = 16'h0000;
  endtask

  task automatic model_step();
    bit writing;
    bit releasing;
    bit ready;
    writing   = m_active && (m_acc > m_wr);
    releasing = m_active && (m_wr == N) && (m_acc == N);
    ready     = m_active && (m_acc == m_wr) && (m_wr < N);
    if (reset) begin
      model_clear();
    end else if (!m_active && start) begin
      m_active = 1'b1;
      m_run    = 1'b0;
      m_acc    = 0;
      m_wr     = 0;
    end else if (ready && ld_valid) begin
      m_acc++;
      m_last = ld_data;
    end else if (writing) begin
      m_wr++;
    end else if (releasing) begin
      m_active = 1'b0;
      m_run    = 1'b1;
      m_loads++;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with what the model predicts for the
  // current cycle and the inputs currently applied.
  task automatic checkOutput();
    bit          writing;
    bit          ready;
    logic        e_we;
    logic [15:0] e_adr;
    logic [15:0] e_din;
    writing = m_active && (m_acc > m_wr);
    ready   = m_active && (m_acc == m_wr) && (m_wr < N);
    e_we    = m_run ? cpu_mw_en : writing;
    e_adr   = m_run ? cpu_adr : 16'(START + 16'(m_wr));
    e_din   = m_run ? cpu_dout : m_last;
    chk("ld_ready",  16'(ld_ready),  16'(ready));
    chk("cpu_reset", 16'(cpu_reset), 16'(!m_run));
    chk("mem_we",    16'(mem_we),    16'(e_we));
    chk("mem_adr",   mem_adr,        e_adr);
    chk("mem_din",   mem_din,        e_din);
    chk("busy",      16'(busy),      16'(m_active));
    chk("done",      16'(done),      16'(m_run));
    chk("word_cnt",  word_cnt,       16'(m_wr));
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [15:0] d,
                               input logic [15:0] ca, input logic [15:0] cd,
                               input logic mw);
    start     = s;
    ld_valid  = v;
    ld_data   = d;
    cpu_adr   = ca;
    cpu_dout  = cd;
    cpu_mw_en = mw;
    #1;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_cycle(input logic s, input logic v, input logic [15:0] d,
                           input logic [15:0] ca, input logic [15:0] cd,
                           input logic mw);
    applyStimulus(s, v, d, ca, cd, mw);
    checkOutput();
    finishCycle();
  endtask

  typedef struct {
    logic        start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_dout;
    logic        cpu_mw_en;
    logic        ready;
    logic        cpu_reset;
    logic        we;
    logic [15:0] adr;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit reached;

    // Full wrap-around load from HOLD, run mux, start in RUN, first cycle of reload.
    vecs[0]  = '{1'b1, 1'b1, 16'hA000, 16'h0010, 16'h1234, 1'b1,  1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'hA000, 16'h0010, 16'h1234, 1'b1,  1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 16'hA001, 16'h0010, 16'h1234, 1'b1,  1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hA000, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 16'hA001, 16'h0000, 16'h0000, 1'b0,  1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hA000, 1'b1, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 16'hA002, 16'h0000, 16'h0000, 1'b0,  1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hA001, 1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 16'hA002, 16'h0000, 16'h0000, 1'b0,  1'b1, 1'b1, 1'b0, 16'h0000, 16'hA001, 1'b1, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, 1'b1, 16'hA003, 16'h0000, 16'h0000, 1'b1,  1'b0, 1'b1, 1'b1, 16'h0000, 16'hA002, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 16'hA003, 16'h0000, 16'h0000, 1'b0,  1'b1, 1'b1, 1'b0, 16'h0001, 16'hA002, 1'b1, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 1'b0,  1'b0, 1'b1, 1'b1, 16'h0001, 16'hA003, 1'b1, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, 1'b1, 16'hBEEF, 16'h0010, 16'h1234, 1'b1,  1'b0, 1'b1, 1'b0, 16'h0002, 16'hA003, 1'b1, 1'b0, 16'd4};
    vecs[10] = '{1'b0, 1'b1, 16'hBEEF, 16'h0010, 16'h1234, 1'b1,  1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b1, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 16'hBEEF, 16'h0020, 16'h5678, 1'b1,  1'b0, 1'b0, 1'b1, 16'h0020, 16'h5678, 1'b0, 1'b1, 16'd4};
    vecs[12] = '{1'b0, 1'b0, 16'hBEEF, 16'h0030, 16'h9ABC, 1'b1,  1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hA003, 1'b1, 1'b0, 16'd0};

    m_loads = 0;
    model_clear();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    checkOutput();
    repeat (2) finishCycle();
    #3 reset = 1'b0;

    $display("[TB] directed table: load, run mux, reload");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].ld_valid, vecs[i].ld_data,
                    vecs[i].cpu_adr, vecs[i].cpu_dout, vecs[i].cpu_mw_en);
      checkOutput();
      chk($sformatf("vec%0d_ld_ready", i),  16'(ld_ready),  16'(vecs[i].ready));
      chk($sformatf("vec%0d_cpu_reset", i), 16'(cpu_reset), 16'(vecs[i].cpu_reset));
      chk($sformatf("vec%0d_mem_we", i),    16'(mem_we),    16'(vecs[i].we));
      chk($sformatf("vec%0d_mem_adr", i),   mem_adr,        vecs[i].adr);
      chk($sformatf("vec%0d_mem_din", i),   mem_din,        vecs[i].din);
      chk($sformatf("vec%0d_busy", i),      16'(busy),      16'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i),      16'(done),      16'(vecs[i].done));
      chk($sformatf("vec%0d_word_cnt", i),  word_cnt,       vecs[i].cnt);
      finishCycle();
    end

    $display("[TB] async reset during the write of the third word");
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'hC000 + 16'(i)), 16'h0000, 16'h0000, 1'b1);
      checkOutput();
      if (m_active && (m_acc > m_wr) && (m_wr == 2)) begin
        reached = 1'b1;
        break;
      end
      finishCycle();
    end
    chk("reach_write3", 16'(reached), 16'd1);
    chk("write3_we", 16'(mem_we), 16'd1);
    #3 reset = 1'b1;
    model_clear();
    #1;
    chk("mid_reset_we",        16'(mem_we),    16'd0);
    chk("mid_reset_cpu_reset", 16'(cpu_reset), 16'd1);
    chk("mid_reset_word_cnt",  word_cnt,       16'd0);
    checkOutput();
    @(posedge clk);
    model_step();
    #1;
    run_cycle(1'b1, 1'b1, 16'h1111, 16'h0000, 16'h0000, 1'b1);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b1, 16'h2222, 16'h0000, 16'h0000, 1'b1);
    end
    chk("after_reset_busy", 16'(busy), 16'd0);

    $display("[TB] randomized traffic against the model");
    for (int i = 0; i < 1500; i++) begin
      run_cycle(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
                16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("[TB] loads completed: %0d", m_loads);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
